// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready word in (in_valid/in_data/in_ready), one bit per clk out (ser_bit/ser_valid/frame_start/frame_done), busy while shifting or holding
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1,
  parameter bit IDLE_BIT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, hold_data, hold_data_n, shifted;
  logic [CW-1:0] cnt, cnt_n;
  logic hold_full, hold_full_n, accept, last;
  assign accept  = in_valid && !hold_full;
  assign last    = state == SHIFT && cnt == LAST;
  assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    cnt_n       = cnt;
    hold_data_n = hold_data;
    hold_full_n = hold_full;
    if (state == IDLE) begin
      if (accept) begin
        sreg_n  = in_data;
        cnt_n   = '0;
        state_n = SHIFT;
      end
    end else if (!last) begin
      sreg_n = shifted;
      cnt_n  = cnt + CW'(1);
      if (accept) begin
        hold_data_n = in_data;
        hold_full_n = 1'b1;
      end
    end else if (hold_full) begin
      sreg_n      = hold_data;
      hold_full_n = 1'b0;
      cnt_n       = '0;
    end else if (in_valid) begin
      sreg_n = in_data;
      cnt_n  = '0;
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      hold_data <= hold_data_n;
      hold_full <= hold_full_n;
    end
  end
  assign in_ready    = !hold_full;
  assign ser_valid   = state == SHIFT;
  assign ser_bit     = ser_valid ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;
  assign frame_start = ser_valid && cnt == '0;
  assign frame_done  = last;
  assign busy        = ser_valid || hold_full;
endmodule
